// File: rtl/fpu_param.sv
// Multi-cycle parameterised floating-point add/subtract unit with no denormals or inf/NaN encodings.
// Pipeline of FSM states ALIGN, ADD, NORM, ROUND; one-hot status and a done pulse accompany each result.
module fpu_param #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 26
) (
  input  logic                   clock100KHz,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   op_sel,
  input  logic [EXP_W+MAN_W:0]   op_a_in,
  input  logic [EXP_W+MAN_W:0]   op_b_in,
  output logic [EXP_W+MAN_W:0]   data_out,
  output logic [3:0]             status_out,
  output logic                   busy,
  output logic                   done
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int X  = MAN_W + 4;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic [3:0] ST_EXACT     = 4'b0001;
  localparam logic [3:0] ST_INEXACT   = 4'b0010;
  localparam logic [3:0] ST_OVERFLOW  = 4'b0100;
  localparam logic [3:0] ST_UNDERFLOW = 4'b1000;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_e;

  // Extended mantissa layout: {hidden, stored mantissa, guard, round, sticky}.
  function automatic logic [X-1:0] ext_man(input logic [W-1:0] word, input logic is_zero);
    logic [X-1:0] res;
    if (is_zero) begin
      res = {X{1'b0}};
    end else begin
      res = {1'b1, word[MAN_W-1:0], 3'b000};
    end
    return res;
  endfunction

  function automatic logic [X-1:0] shr_sticky(input logic [X-1:0] m, input logic [EXP_W-1:0] d);
    logic [X-1:0] mask;
    logic [X-1:0] res;
    mask = ~({X{1'b1}} << d);
    if (int'(d) >= MAN_W + 3) begin
      res = {{(X-1){1'b0}}, |m};
    end else begin
      res    = m >> d;
      res[0] = res[0] | (|(m & mask));
    end
    return res;
  endfunction

  state_e               state_q;
  logic [W-1:0]         a_q, b_q, data_q;
  logic                 op_q, sign_q, eff_sub_q, busy_q, done_q;
  logic signed [EW-1:0] exp_q;
  logic [X-1:0]         big_q, small_q, m_q;
  logic [3:0]           status_q;

  logic                 a_zero_s, b_zero_s, b_sign_s, a_ge_s, norm_pend_s;
  logic                 g_s, r_s, s_s, rnd_up_s;
  logic [W-2:0]         a_mag_s, b_mag_s;
  logic [EXP_W-1:0]     big_exp_s, sml_exp_s;
  logic [X-1:0]         sml_m_s;
  logic [X:0]           sum_s;
  logic [MAN_W+1:0]     man_sum_s;
  logic signed [EW-1:0] exp_rnd_s;
  logic                 sign_d, eff_sub_d;
  logic signed [EW-1:0] exp_align_d, exp_add_d;
  logic [X-1:0]         big_d, small_d, m_add_d;
  logic [W-1:0]         data_d;
  logic [3:0]           status_d;

  // Next-state datapath values for every FSM stage.
  always_comb begin
    a_zero_s = (a_q[W-2:MAN_W] == {EXP_W{1'b0}});
    b_zero_s = (b_q[W-2:MAN_W] == {EXP_W{1'b0}});
    a_mag_s  = a_zero_s ? {(W-1){1'b0}} : a_q[W-2:0];
    b_mag_s  = b_zero_s ? {(W-1){1'b0}} : b_q[W-2:0];
    b_sign_s = b_q[W-1] ^ op_q;
    a_ge_s   = (a_mag_s >= b_mag_s);
    if (a_ge_s) begin
      sign_d    = a_q[W-1];
      big_exp_s = a_q[W-2:MAN_W];
      sml_exp_s = b_q[W-2:MAN_W];
      big_d     = ext_man(a_q, a_zero_s);
      sml_m_s   = ext_man(b_q, b_zero_s);
    end else begin
      sign_d    = b_sign_s;
      big_exp_s = b_q[W-2:MAN_W];
      sml_exp_s = a_q[W-2:MAN_W];
      big_d     = ext_man(b_q, b_zero_s);
      sml_m_s   = ext_man(a_q, a_zero_s);
    end
    small_d     = shr_sticky(sml_m_s, big_exp_s - sml_exp_s);
    eff_sub_d   = a_q[W-1] ^ b_sign_s;
    exp_align_d = signed'({2'b00, big_exp_s});

    if (eff_sub_q) begin
      sum_s = {1'b0, big_q} - {1'b0, small_q};
    end else begin
      sum_s = {1'b0, big_q} + {1'b0, small_q};
    end
    // A carry folds the shifted-out bit into sticky so rounding still sees it.
    if (sum_s[X]) begin
      m_add_d   = {sum_s[X:2], sum_s[1] | sum_s[0]};
      exp_add_d = exp_q + EXP_ONE;
    end else begin
      m_add_d   = sum_s[X-1:0];
      exp_add_d = exp_q;
    end

    norm_pend_s = (m_q != {X{1'b0}}) && !m_q[X-1];

    g_s       = m_q[2];
    r_s       = m_q[1];
    s_s       = m_q[0];
    rnd_up_s  = g_s & (r_s | s_s | m_q[3]);
    man_sum_s = {1'b0, m_q[X-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up_s};
    if (man_sum_s[MAN_W+1]) begin
      exp_rnd_s = exp_q + EXP_ONE;
    end else begin
      exp_rnd_s = exp_q;
    end

    if (m_q == {X{1'b0}}) begin
      data_d   = {W{1'b0}};
      status_d = ST_EXACT;
    end else if (exp_rnd_s > EXP_MAX) begin
      data_d   = {sign_q, {(W-1){1'b1}}};
      status_d = ST_OVERFLOW;
    end else if (exp_rnd_s < EXP_ONE) begin
      data_d   = {sign_q, {(W-1){1'b0}}};
      status_d = ST_UNDERFLOW;
    end else if (man_sum_s[MAN_W+1]) begin
      data_d   = {sign_q, exp_rnd_s[EXP_W-1:0], man_sum_s[MAN_W:1]};
      status_d = (g_s | r_s | s_s) ? ST_INEXACT : ST_EXACT;
    end else begin
      data_d   = {sign_q, exp_rnd_s[EXP_W-1:0], man_sum_s[MAN_W-1:0]};
      status_d = (g_s | r_s | s_s) ? ST_INEXACT : ST_EXACT;
    end
  end

  // Control FSM together with all datapath and output registers.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      a_q       <= {W{1'b0}};
      b_q       <= {W{1'b0}};
      op_q      <= 1'b0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      exp_q     <= {EW{1'b0}};
      big_q     <= {X{1'b0}};
      small_q   <= {X{1'b0}};
      m_q       <= {X{1'b0}};
      data_q    <= {W{1'b0}};
      status_q  <= 4'b0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= op_a_in;
            b_q     <= op_b_in;
            op_q    <= op_sel;
            busy_q  <= 1'b1;
            state_q <= ALIGN;
          end
        end
        ALIGN: begin
          sign_q    <= sign_d;
          eff_sub_q <= eff_sub_d;
          exp_q     <= exp_align_d;
          big_q     <= big_d;
          small_q   <= small_d;
          state_q   <= ADD;
        end
        ADD: begin
          m_q     <= m_add_d;
          exp_q   <= exp_add_d;
          state_q <= NORM;
        end
        NORM: begin
          if (norm_pend_s) begin
            m_q   <= {m_q[X-2:0], 1'b0};
            exp_q <= exp_q - EXP_ONE;
          end else begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          data_q   <= data_d;
          status_q <= status_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_out   = data_q;
  assign status_out = status_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fpu_param.sv
// Self-checking bench for fpu_param: vector table driven through a scoreboard queue,
// plus back-to-back and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_fpu_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op_sel = 1'b0;
  logic [31:0] op_a_in = 32'h0;
  logic [31:0] op_b_in = 32'h0;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic        busy;
  logic        done;

  fpu_param dut (
    .clock100KHz(clk),
    .reset      (reset),
    .start      (start),
    .op_sel     (op_sel),
    .op_a_in    (op_a_in),
    .op_b_in    (op_b_in),
    .data_out   (data_out),
    .status_out (status_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic [3:0]  s;
    int          lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] d;
    logic [3:0]  s;
    int          lat;
    int          c0;
  } exp_t;

  localparam logic [3:0] EX = 4'b0001;
  localparam logic [3:0] IN = 4'b0010;
  localparam logic [3:0] OV = 4'b0100;
  localparam logic [3:0] UN = 4'b1000;

  vec_t vt[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic add_vec(input string name, input logic op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] d, input logic [3:0] s,
                         input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.d = d; v.s = s; v.lat = lat;
    vt.push_back(v);
  endtask

  task automatic issue(input vec_t v);
    exp_t e;
    op_a_in = v.a;
    op_b_in = v.b;
    op_sel  = v.op;
    start   = 1'b1;
    e.name = v.name; e.d = v.d; e.s = v.s; e.lat = v.lat; e.c0 = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 80 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no done within 80 cycles, expected completion", name);
      sb.delete();
    end
  endtask

  // Apply one vector, then scramble inputs and poke start while busy.
  task automatic run(input vec_t v);
    @(negedge clk);
    issue(v);
    @(negedge clk);
    start   = 1'b0;
    op_a_in = $urandom;
    op_b_in = $urandom;
    op_sel  = ~v.op;
    chk({v.name, "_busy"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(v.name);
  endtask

  // Scoreboard consumer: every done pops one expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: got done=1, expected no pending operation");
      end else begin
        e = sb.pop_front();
        chk({e.name, "_data"}, data_out, e.d);
        chk({e.name, "_status"}, {28'd0, status_out}, {28'd0, e.s});
        chk({e.name, "_latency"}, 32'(cyc - e.c0 + 1), 32'(e.lat));
        chk({e.name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation time limit, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    #2;
    chk("reset_data", data_out, 32'h0);
    chk("reset_status", {28'd0, status_out}, 32'h0);
    chk("reset_busy_done", {30'd0, busy, done}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    add_vec("add_one_one",     1'b0, 32'h3C000000, 32'h3C000000, 32'h40000000, EX, 5);
    add_vec("sub_one_one",     1'b1, 32'h3C000000, 32'h3C000000, 32'h00000000, EX, 5);
    add_vec("ovf_max",         1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, OV, 5);
    add_vec("unf_pos",         1'b1, 32'h06000000, 32'h04000000, 32'h00000000, UN, 6);
    add_vec("inexact_sticky",  1'b0, 32'h7C000000, 32'h04000000, 32'h7C000000, IN, 5);
    add_vec("add_neg_cancel",  1'b0, 32'h3C000000, 32'hBC000000, 32'h00000000, EX, 5);
    add_vec("carry_norm",      1'b0, 32'h3E000000, 32'h38000000, 32'h40000000, EX, 5);
    add_vec("one_shift",       1'b1, 32'h3C000000, 32'h38000000, 32'h38000000, EX, 6);
    add_vec("two_shift",       1'b1, 32'h40000000, 32'h3E000000, 32'h38000000, EX, 7);
    add_vec("neg_add",         1'b1, 32'hBC000000, 32'h3C000000, 32'hC0000000, EX, 5);
    add_vec("zero_operand",    1'b0, 32'h03FFFFFF, 32'h3C000000, 32'h3C000000, EX, 5);
    add_vec("tie_even_down",   1'b0, 32'h7C000000, 32'h10000000, 32'h7C000000, IN, 5);
    add_vec("tie_odd_up",      1'b0, 32'h7C000001, 32'h10000000, 32'h7C000002, IN, 5);
    add_vec("round_carry",     1'b0, 32'h7BFFFFFF, 32'h0C000000, 32'h7C000000, IN, 5);
    add_vec("round_ovf",       1'b0, 32'h7FFFFFFF, 32'h10000000, 32'h7FFFFFFF, OV, 5);
    add_vec("neg_ovf",         1'b1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, OV, 5);
    add_vec("unf_neg",         1'b1, 32'h04000000, 32'h06000000, 32'h80000000, UN, 6);
    add_vec("align_round_bit", 1'b0, 32'h7C000000, 32'h0C000000, 32'h7C000000, IN, 5);
    add_vec("align_max_shift", 1'b0, 32'h7C000000, 32'h08000000, 32'h7C000000, IN, 5);
    add_vec("both_zero",       1'b1, 32'h00000000, 32'h80000000, 32'h00000000, EX, 5);

    for (int i = 0; i < vt.size(); i++) run(vt[i]);

    // Back-to-back: new start in the done cycle.
    @(negedge clk);
    issue(vt[0]);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40 && done !== 1'b1; k++) @(negedge clk);
    if (done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL b2b_first_timeout: got no done, expected done within 40 cycles");
    end
    v = vt[7];
    v.name = "b2b_second";
    issue(v);
    @(negedge clk);
    start = 1'b0;
    drain("b2b");

    // Reset two cycles into an operation aborts it silently.
    @(negedge clk);
    op_a_in = 32'h3C000000;
    op_b_in = 32'h3C000000;
    op_sel  = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_data", data_out, 32'h0);
    chk("abort_status", {28'd0, status_out}, 32'h0);
    chk("abort_busy_done", {30'd0, busy, done}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    v = vt[0];
    v.name = "after_reset";
    run(v);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
